// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full adder, LSB first, with start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add a registered signed-overflow output 'ovf'.

module fa (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic c_in
);
  assign sum   = a ^ b ^ c_in;
  assign carry = (a & b) | (a & c_in) | (b & c_in);
endmodule

module serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         busy,
`ifdef SERIAL_ADDER_OVF_EN
  output logic         ovf,
`endif
  output logic         done
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sa_q, sa_d;
  logic [W-1:0]   sb_q, sb_d;
  // Only W-1 bits are stored; the last sum bit comes straight from the adder at completion.
  logic [W-2:0]   sr_q, sr_d;
  logic           cr_q, cr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  logic faSum;
  logic faCarry;

  fa u_fa (faSum, faCarry, sa_q[0], sb_q[0], cr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      cr_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      cr_q    <= cr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    cr_d    = cr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cr_d    = c_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        cr_d = faCarry;
        if (W > 2) sr_d = {faSum, sr_q[W-2:1]};
        else       sr_d = faSum;
        if (cnt_q == LAST) begin
          sum_d   = {faSum, sr_q};
          cout_d  = faCarry;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
          // cr_q is the carry into the MSB during the final bit.
          ovf_d   = cr_q ^ faCarry;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign sum   = sum_q;
  assign c_out = cout_q;
  assign busy  = busy_q;
  assign done  = done_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder (W=8) against an arithmetic reference model.
// Exercises the ovf output as well when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;
  logic         done;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int nChecks = 0;
  int nFails  = 0;

  serial_adder #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out),
    .busy  (busy),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference: unsigned total for {c_out,sum}, signed total range for ovf.
  function automatic void refAdd(input logic [7:0] x, input logic [7:0] y, input logic ci,
                                 output logic [7:0] s, output logic co, output logic ov);
    int u;
    int sv;
    u  = int'(x) + int'(y) + int'(ci);
    sv = int'($signed(x)) + int'($signed(y)) + int'(ci);
    s  = u[7:0];
    co = (u > 255);
    ov = (sv > 127) || (sv < -128);
  endfunction

  function automatic logic readOvf();
`ifdef SERIAL_ADDER_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one operation and collects observations; all judgements are made by the caller.
  task automatic doOp(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                      input bit pulseIgnored,
                      output logic [7:0] s, output logic co, output logic ov,
                      output int lat, output bit busyOk, output bit heldOk,
                      output logic [7:0] heldSum, output bit doneOneCycle);
    logic heldCo;
    @(negedge clk);
    a = ai; b = bi; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
    heldSum = sum; heldCo = c_out;
    lat = 0; busyOk = 1'b1; heldOk = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      if (sum !== heldSum || c_out !== heldCo) heldOk = 1'b0;
      start = (pulseIgnored && (lat == 2 || lat == 7));
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    s  = sum;
    co = c_out;
    ov = readOvf();
    if (busy !== 1'b0) busyOk = 1'b0;
    @(negedge clk);
    doneOneCycle = (done === 1'b0);
  endtask

  task automatic checkOp(input string name, input logic [7:0] ai, input logic [7:0] bi,
                         input logic ci, input logic [7:0] s, input logic co, input logic ov,
                         input int lat, input bit busyOk, input bit doneOneCycle);
    logic [7:0] es;
    logic eco, eov;
    refAdd(ai, bi, ci, es, eco, eov);
    nChecks++;
    if ({co, s} !== {eco, es}) begin
      nFails++;
      $display("[TB] FAIL %s result: got c_out=%0b sum=%02h, expected c_out=%0b sum=%02h",
               name, co, s, eco, es);
    end
    nChecks++;
    if (lat !== W) begin
      nFails++;
      $display("[TB] FAIL %s latency: done after %0d edges, expected %0d", name, lat, W);
    end
    nChecks++;
    if (busyOk !== 1'b1 || doneOneCycle !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL %s handshake: busyOk=%0b doneOneCycle=%0b, expected 1 1",
               name, busyOk, doneOneCycle);
    end
`ifdef SERIAL_ADDER_OVF_EN
    nChecks++;
    if (ov !== eov) begin
      nFails++;
      $display("[TB] FAIL %s ovf: got %0b, expected %0b", name, ov, eov);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    nChecks++;
    if ({sum, c_out, busy, done, readOvf()} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_asserted: got sum=%02h c_out=%0b busy=%0b done=%0b, expected all 0",
               sum, c_out, busy, done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    nChecks++;
    if ({sum, c_out, busy, done} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_idle: got sum=%02h c_out=%0b busy=%0b done=%0b, expected all 0",
               sum, c_out, busy, done);
    end
  endtask

  task automatic test_zero();
    logic [7:0] s, hs; logic co, ov; int lat; bit bo, ho, d1;
    doOp(8'h00, 8'h00, 1'b0, 1'b0, s, co, ov, lat, bo, ho, hs, d1);
    checkOp("zero", 8'h00, 8'h00, 1'b0, s, co, ov, lat, bo, d1);
  endtask

  task automatic test_carry_wrap();
    logic [7:0] s, hs; logic co, ov; int lat; bit bo, ho, d1;
    doOp(8'hFF, 8'h01, 1'b0, 1'b0, s, co, ov, lat, bo, ho, hs, d1);
    checkOp("carry_wrap", 8'hFF, 8'h01, 1'b0, s, co, ov, lat, bo, d1);
  endtask

  task automatic test_ignore_start();
    logic [7:0] s, hs; logic co, ov; int lat; bit bo, ho, d1; int extraDone;
    doOp(8'h5A, 8'h33, 1'b1, 1'b1, s, co, ov, lat, bo, ho, hs, d1);
    checkOp("ignore_start", 8'h5A, 8'h33, 1'b1, s, co, ov, lat, bo, d1);
    extraDone = 0;
    repeat (12) begin
      if (done === 1'b1 || busy === 1'b1) extraDone++;
      @(negedge clk);
    end
    nChecks++;
    if (extraDone !== 0 || sum !== 8'h8E || c_out !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL ignore_start_after: extra activity=%0d sum=%02h c_out=%0b, expected 0 8e 0",
               extraDone, sum, c_out);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] s, hs; logic co, ov; int lat; bit bo, ho, d1; int seenDone;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nChecks++;
    if ({sum, c_out, busy, done, readOvf()} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_abort: got sum=%02h c_out=%0b busy=%0b done=%0b, expected all 0",
               sum, c_out, busy, done);
    end
    seenDone = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      if (done !== 1'b0 || busy !== 1'b0) seenDone++;
      @(negedge clk);
    end
    nChecks++;
    if (seenDone !== 0) begin
      nFails++;
      $display("[TB] FAIL reset_abort_quiet: %0d cycles with busy/done, expected 0", seenDone);
    end
    doOp(8'hAA, 8'h55, 1'b1, 1'b0, s, co, ov, lat, bo, ho, hs, d1);
    checkOp("after_reset", 8'hAA, 8'h55, 1'b1, s, co, ov, lat, bo, d1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] s, hs; logic co, ov; int lat; bit bo, ho, d1;
    doOp(8'h10, 8'h20, 1'b0, 1'b0, s, co, ov, lat, bo, ho, hs, d1);
    checkOp("b2b_first", 8'h10, 8'h20, 1'b0, s, co, ov, lat, bo, d1);
    doOp(8'hF0, 8'h20, 1'b0, 1'b0, s, co, ov, lat, bo, ho, hs, d1);
    checkOp("b2b_second", 8'hF0, 8'h20, 1'b0, s, co, ov, lat, bo, d1);
    nChecks++;
    if (ho !== 1'b1 || hs !== 8'h30) begin
      nFails++;
      $display("[TB] FAIL b2b_hold: held=%0b sum during RUN=%02h, expected 1 30", ho, hs);
    end
  endtask

  task automatic test_random();
    logic [7:0] s, hs, ra, rb; logic rc, co, ov; int lat; bit bo, ho, d1;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      if (i == 0) begin ra = 8'h80; rb = 8'h80; rc = 1'b0; end
      if (i == 1) begin ra = 8'hFF; rb = 8'hFF; rc = 1'b1; end
      doOp(ra, rb, rc, i[0], s, co, ov, lat, bo, ho, hs, d1);
      checkOp("random", ra, rb, rc, s, co, ov, lat, bo, d1);
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [7:0] s, hs; logic co, ov; int lat; bit bo, ho, d1;
    doOp(8'h7F, 8'h01, 1'b0, 1'b0, s, co, ov, lat, bo, ho, hs, d1);
    checkOp("ovf_pos", 8'h7F, 8'h01, 1'b0, s, co, ov, lat, bo, d1);
    doOp(8'hFF, 8'h01, 1'b0, 1'b0, s, co, ov, lat, bo, ho, hs, d1);
    checkOp("ovf_none", 8'hFF, 8'h01, 1'b0, s, co, ov, lat, bo, d1);
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_carry_wrap();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
